// File: rtl/bcd_display_scheduler_pkg.sv
// Shared types and constants for the BCD display scheduler: FSM states,
// field indices, digit pair struct and range limits.
package bcd_display_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONV_S = 3'd1,
    CONV_M = 3'd2,
    CONV_H = 3'd3,
    DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    FLD_S = 2'd0,
    FLD_M = 2'd1,
    FLD_H = 2'd2
  } field_t;

  typedef struct packed {
    logic [3:0] msb;
    logic [3:0] lsb;
  } bcd_pair_t;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [6:0] SEC_MAX   = 7'd59;
  localparam logic [6:0] MIN_MAX   = 7'd59;

  // Which snapshot field the shared converter sees in a given state.
  function automatic field_t field_of(input state_t st);
    case (st)
      CONV_M:  field_of = FLD_M;
      CONV_H:  field_of = FLD_H;
      default: field_of = FLD_S;
    endcase
  endfunction

endpackage

// File: rtl/bcd_display_scheduler_binary_to_bcd.sv
// Combinational 7-bit binary to two-digit BCD converter (double dabble).
// Values above 99 produce 4'hF on both digits.
module binary_to_bcd
  import bcd_display_scheduler_pkg::*;
(
  input  logic [6:0] bin,
  output bcd_pair_t  digits
);

  // sr: [15] hundreds bit, [14:11] tens, [10:7] ones, [6:0] shifting binary
  logic [15:0] sr;

  always_comb begin
    sr = {9'd0, bin};
    for (int i = 0; i < 7; i++) begin
      if (sr[14:11] >= 4'd5) sr[14:11] = sr[14:11] + 4'd3;
      if (sr[10:7]  >= 4'd5) sr[10:7]  = sr[10:7]  + 4'd3;
      sr = sr << 1;
    end
  end

  always_comb begin
    if (sr[15]) begin
      digits.msb = BCD_BLANK;
      digits.lsb = BCD_BLANK;
    end else begin
      digits.msb = sr[14:11];
      digits.lsb = sr[10:7];
    end
  end

endmodule

// File: rtl/bcd_display_scheduler.sv
// Time-shares one binary_to_bcd between seconds/minutes/hours and publishes a
// coherent 6-digit BCD word. Optional macro BCD_SCHED_LEAD_BLANK_EN blanks a zero hours msb.
module bcd_display_scheduler
  import bcd_display_scheduler_pkg::*;
#(
  parameter int HOUR_MAX = 23
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_refresh,
  input  logic [6:0]  i_seconds,
  input  logic [6:0]  i_minutes,
  input  logic [6:0]  i_hours,
  output logic [23:0] o_bcd,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_range_err
);

  localparam logic [6:0] HRS_MAX = 7'(HOUR_MAX);

  state_t     state;
  logic [6:0] snap_s, snap_m, snap_h;
  bcd_pair_t  stage_s, stage_m, stage_h;
  logic       pending;

  logic [6:0] conv_in;
  bcd_pair_t  conv_out;
  logic       range_err;
  logic [3:0] h_msb;

  always_comb begin
    case (field_of(state))
      FLD_M:   conv_in = snap_m;
      FLD_H:   conv_in = snap_h;
      default: conv_in = snap_s;
    endcase
  end

  binary_to_bcd u_conv (
    .bin    (conv_in),
    .digits (conv_out)
  );

  assign range_err = (snap_s > SEC_MAX) | (snap_m > MIN_MAX) | (snap_h > HRS_MAX);

  always_comb begin
    h_msb = stage_h.msb;
`ifdef BCD_SCHED_LEAD_BLANK_EN
    if (stage_h.msb == 4'd0) h_msb = BCD_BLANK;
`endif
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      snap_s      <= '0;
      snap_m      <= '0;
      snap_h      <= '0;
      stage_s     <= '0;
      stage_m     <= '0;
      stage_h     <= '0;
      pending     <= 1'b0;
      o_bcd       <= '0;
      o_valid     <= 1'b0;
      o_busy      <= 1'b0;
      o_range_err <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_refresh) begin
            snap_s <= i_seconds;
            snap_m <= i_minutes;
            snap_h <= i_hours;
            state  <= CONV_S;
            o_busy <= 1'b1;
          end
        end
        CONV_S: begin
          stage_s <= conv_out;
          state   <= CONV_M;
          if (i_refresh) pending <= 1'b1;
        end
        CONV_M: begin
          stage_m <= conv_out;
          state   <= CONV_H;
          if (i_refresh) pending <= 1'b1;
        end
        CONV_H: begin
          stage_h <= conv_out;
          state   <= DONE;
          if (i_refresh) pending <= 1'b1;
        end
        DONE: begin
          o_bcd       <= {h_msb, stage_h.lsb, stage_m, stage_s};
          o_valid     <= 1'b1;
          o_range_err <= range_err;
          // A refresh seen now or earlier restarts straight away, no IDLE gap.
          if (pending || i_refresh) begin
            pending <= 1'b0;
            snap_s  <= i_seconds;
            snap_m  <= i_minutes;
            snap_h  <= i_hours;
            state   <= CONV_S;
          end else begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          pending <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Self-checking bench for bcd_display_scheduler against an arithmetic reference model.
module tb_bcd_display_scheduler;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_refresh = 1'b0;
  logic [6:0]  i_seconds = '0;
  logic [6:0]  i_minutes = '0;
  logic [6:0]  i_hours = '0;
  logic [23:0] o_bcd;
  logic        o_valid;
  logic        o_busy;
  logic        o_range_err;

  int vectors = 0;
  int miscompares = 0;

  bcd_display_scheduler #(.HOUR_MAX(23)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_refresh   (i_refresh),
    .i_seconds   (i_seconds),
    .i_minutes   (i_minutes),
    .i_hours     (i_hours),
    .o_bcd       (o_bcd),
    .o_valid     (o_valid),
    .o_busy      (o_busy),
    .o_range_err (o_range_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: decimal digits by division, 0xFF for anything above 99.
  function automatic logic [7:0] ref_pair(input int v);
    logic [3:0] t, o;
    if (v > 99) return 8'hFF;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic logic [23:0] ref_bcd(input int s, input int m, input int h);
    logic [7:0] hp;
    hp = ref_pair(h);
`ifdef BCD_SCHED_LEAD_BLANK_EN
    if (hp[7:4] == 4'd0) hp[7:4] = 4'hF;
`endif
    return {hp, ref_pair(m), ref_pair(s)};
  endfunction

  function automatic logic ref_err(input int s, input int m, input int h);
    return (s > 59) || (m > 59) || (h > 23);
  endfunction

  // Drives one refresh from idle and waits (bounded) for the valid pulse.
  // lat counts edges after the sampling edge; busy_bad counts non-busy cycles before valid.
  task automatic do_xact(input int s, input int m, input int h, output int lat,
                         output logic [23:0] bcd, output logic err, output int busy_bad);
    i_seconds = 7'(s); i_minutes = 7'(m); i_hours = 7'(h);
    i_refresh = 1'b1;
    @(posedge i_clk); #1;
    i_refresh = 1'b0;
    lat = 0; busy_bad = 0;
    while (!o_valid && lat < 12) begin
      if (!o_busy) busy_bad++;
      @(posedge i_clk); #1;
      lat++;
    end
    bcd = o_bcd;
    err = o_range_err;
  endtask

  task automatic test_reset;
    #3;
    vectors++;
    if (o_bcd !== 24'h0 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_range_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: bcd=%h valid=%b busy=%b err=%b required all 0",
               o_bcd, o_valid, o_busy, o_range_err);
    end
    repeat (2) @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_basic;
    int lat, bb; logic [23:0] bcd; logic err;
    do_xact(45, 7, 13, lat, bcd, err, bb);
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL basic_latency: got %0d required 4", lat); end
    vectors++;
    if (bcd !== 24'h130745) begin miscompares++; $display("FAIL basic_bcd: got %h required 130745", bcd); end
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL basic_err: got %b required 0", err); end
    vectors++;
    if (bb !== 0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_busy: non-busy cycles %0d, busy with valid %b, required 0/0", bb, o_busy);
    end
    @(posedge i_clk); #1;
    vectors++;
    if (o_valid !== 1'b0) begin miscompares++; $display("FAIL basic_pulse_width: valid %b required 0", o_valid); end
  endtask

  task automatic test_coherence;
    int lat = 0;
    i_seconds = 7'd45; i_minutes = 7'd7; i_hours = 7'd13;
    i_refresh = 1'b1;
    @(posedge i_clk); #1;
    i_refresh = 1'b0;
    i_seconds = 7'd59; i_minutes = 7'd59; i_hours = 7'd23;
    while (!o_valid && lat < 12) begin @(posedge i_clk); #1; lat++; end
    vectors++;
    if (lat !== 4 || o_bcd !== 24'h130745) begin
      miscompares++;
      $display("FAIL coherence: lat %0d bcd %h required 4 / 130745", lat, o_bcd);
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_back_to_back;
    int nval = 0, bb = 0;
    int vlat[4];
    logic [23:0] vbcd[4];
    i_seconds = 7'd10; i_minutes = 7'd20; i_hours = 7'd8;
    i_refresh = 1'b1;
    @(posedge i_clk); #1;
    i_seconds = 7'd33; i_minutes = 7'd44; i_hours = 7'd11;
    for (int lat = 0; lat <= 12; lat++) begin
      if (o_valid && nval < 4) begin vlat[nval] = lat; vbcd[nval] = o_bcd; nval++; end
      if (lat <= 7 && !o_busy) bb++;
      if (lat == 2) i_refresh = 1'b0;
      if (lat == 4) begin i_seconds = 7'd1; i_minutes = 7'd2; i_hours = 7'd3; end
      @(posedge i_clk); #1;
    end
    vectors++;
    if (nval !== 2) begin
      miscompares++; $display("FAIL b2b_count: got %0d valid pulses required 2", nval);
    end else begin
      vectors++;
      if (vlat[0] !== 4 || vlat[1] - vlat[0] !== 4) begin
        miscompares++; $display("FAIL b2b_spacing: pulses at %0d,%0d required 4,8", vlat[0], vlat[1]);
      end
      vectors++;
      if (vbcd[0] !== ref_bcd(10, 20, 8)) begin
        miscompares++; $display("FAIL b2b_first: got %h required %h", vbcd[0], ref_bcd(10, 20, 8));
      end
      vectors++;
      if (vbcd[1] !== ref_bcd(33, 44, 11)) begin
        miscompares++; $display("FAIL b2b_second: got %h required %h", vbcd[1], ref_bcd(33, 44, 11));
      end
    end
    vectors++;
    if (bb !== 0) begin miscompares++; $display("FAIL b2b_busy: %0d idle cycles, required 0", bb); end
  endtask

  task automatic test_range;
    int lat, bb; logic [23:0] bcd; logic err;
    do_xact(30, 15, 24, lat, bcd, err, bb);
    vectors++;
    if (bcd[23:16] !== 8'h24 || err !== 1'b1) begin
      miscompares++; $display("FAIL range_hours: bcd %h err %b required 24xxxx / 1", bcd, err);
    end
    @(posedge i_clk); #1;
    do_xact(120, 5, 6, lat, bcd, err, bb);
    vectors++;
    if (bcd[7:0] !== 8'hFF || err !== 1'b1 || bcd !== ref_bcd(120, 5, 6)) begin
      miscompares++; $display("FAIL range_seconds: bcd %h err %b required %h / 1", bcd, err, ref_bcd(120, 5, 6));
    end
    @(posedge i_clk); #1;
    do_xact(59, 59, 23, lat, bcd, err, bb);
    vectors++;
    if (err !== 1'b0 || bcd !== ref_bcd(59, 59, 23)) begin
      miscompares++; $display("FAIL range_edge: bcd %h err %b required %h / 0", bcd, err, ref_bcd(59, 59, 23));
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_macro;
    int lat, bb; logic [23:0] bcd, exp_bcd; logic err;
`ifdef BCD_SCHED_LEAD_BLANK_EN
    exp_bcd = 24'hF53000;
`else
    exp_bcd = 24'h053000;
`endif
    do_xact(0, 30, 5, lat, bcd, err, bb);
    vectors++;
    if (bcd !== exp_bcd || lat !== 4) begin
      miscompares++; $display("FAIL macro_blank: bcd %h lat %0d required %h / 4", bcd, lat, exp_bcd);
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset_mid;
    int act = 0;
    i_seconds = 7'd12; i_minutes = 7'd34; i_hours = 7'd21;
    i_refresh = 1'b1;
    @(posedge i_clk); #1;            // CONV_S; refresh held to set pending
    @(posedge i_clk); #1;            // CONV_M
    i_refresh = 1'b0;
    #2 i_reset_n = 1'b0;
    #1;
    vectors++;
    if (o_bcd !== 24'h0 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_range_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: bcd=%h valid=%b busy=%b err=%b required all 0", o_bcd, o_valid, o_busy, o_range_err);
    end
    @(posedge i_clk); #1 i_reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge i_clk); #1;
      if (o_valid || o_busy) act++;
    end
    vectors++;
    if (act !== 0) begin miscompares++; $display("FAIL reset_idle: %0d active cycles after reset, required 0", act); end
  endtask

  task automatic test_random;
    int lat, bb, s, m, h; logic [23:0] bcd; logic err;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        s = $urandom_range(0, 127); m = $urandom_range(0, 127); h = $urandom_range(0, 127);
      end else begin
        s = $urandom_range(0, 59); m = $urandom_range(0, 59); h = $urandom_range(0, 23);
      end
      do_xact(s, m, h, lat, bcd, err, bb);
      vectors++;
      if (lat !== 4 || bcd !== ref_bcd(s, m, h) || err !== ref_err(s, m, h) || bb !== 0) begin
        miscompares++;
        $display("FAIL random[%0d] s=%0d m=%0d h=%0d: lat %0d bcd %h err %b busy_gaps %0d required 4 %h %b 0",
                 n, s, m, h, lat, bcd, err, bb, ref_bcd(s, m, h), ref_err(s, m, h));
      end
      repeat ($urandom_range(1, 3)) @(posedge i_clk);
      #1;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_coherence;
    test_back_to_back;
    test_range;
    test_macro;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
